// File: rtl/br_resolver_pkg.sv
// Shared definitions for the branch resolver and its prediction queue.
// Queue entry layout {pred, pc, target} = 65 bits:
//   [64]    predicted taken
//   [63:32] PC of the predicted instruction
//   [31:0]  predicted next PC
package br_resolver_pkg;

  localparam int unsigned BRQ_W       = 65;
  localparam int unsigned BRQ_PRED    = 64;
  localparam int unsigned BRQ_PC_LSB  = 32;
  localparam int unsigned BRQ_TGT_LSB = 0;

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } br_state_e;

  // Architecturally correct next PC for a resolved control-flow instruction.
  function automatic logic [31:0] calc_next_pc(input logic        taken,
                                               input logic [31:0] pc,
                                               input logic [31:0] target);
    return taken ? target : (pc + 32'd4);
  endfunction

endpackage

// File: rtl/br_queue.sv
// Synchronous FIFO of in-flight branch predictions.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   i_push/i_data  write one entry (ignored when full or clearing)
//   i_pop          drop the head entry (ignored when empty or clearing)
//   i_clear        empty the queue; wins over push and pop in the same cycle
//   o_head         entry at the head (undefined content when empty)
//   o_full/o_empty occupancy flags
module br_queue
  import br_resolver_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [BRQ_W-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [BRQ_W-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);

  // One extra pointer bit separates full from empty once the pointers wrap.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [BRQ_W-1:0] r_mem [QUEUE_DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/br_resolver.sv
// Execute-side branch resolver. Queues fetch predictions, checks each against the
// resolved outcome, trains the predictor, redirects/flushes fetch on a mispredict and
// keeps branch/mispredict statistics.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   push_*                            prediction from fetch; push_ready_o stalls fetch
//   ex_*                              resolved outcome from execute
//   br_sig_o, miss_pred_o             predictor training pulse (BRANCH/JAL only)
//   redirect_o, redirect_pc_o         one-cycle fetch redirect with correct PC
//   flush_o                           kill wrong-path instructions in IF/ID
//   sync_err_o                        sticky: execute and queue disagreed
//   branch_cnt_o, miss_cnt_o          statistics counters
module br_resolver
  import br_resolver_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid_i,
  input  logic             push_pred_i,
  input  logic [31:0]      push_pc_i,
  input  logic [31:0]      push_target_i,
  output logic             push_ready_o,
  input  logic             ex_valid_i,
  input  logic             ex_is_jalr_i,
  input  logic             ex_taken_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_target_i,
  output logic             br_sig_o,
  output logic             miss_pred_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             sync_err_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e        r_state;
  logic [FcW-1:0]   r_flush_cnt;

  logic             w_idle;
  logic             w_push_fire;
  logic             w_resolve;
  logic [BRQ_W-1:0] w_push_data;
  logic [BRQ_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_head_pred;
  logic [31:0]      w_head_pc;
  logic [31:0]      w_head_tgt;
  logic             w_sync_bad;
  logic             w_miss_br;
  logic             w_miss_jalr;
  logic             w_miss;
  logic             w_mispredict;
  logic [31:0]      w_next_pc;

  assign w_idle       = (r_state == StIdle);
  assign push_ready_o = !w_full && w_idle;
  assign w_push_fire  = push_valid_i && push_ready_o;
  assign w_resolve    = ex_valid_i && w_idle;
  assign w_push_data  = {push_pred_i, push_pc_i, push_target_i};

  assign w_head_pred  = w_head[BRQ_PRED];
  assign w_head_pc    = w_head[BRQ_PC_LSB +: 32];
  assign w_head_tgt   = w_head[BRQ_TGT_LSB +: 32];

  // A missing or mismatched head means fetch and execute lost sync; recover by redirecting.
  assign w_sync_bad   = w_empty || (w_head_pc != ex_pc_i);
  assign w_miss_br    = (ex_taken_i != w_head_pred) ||
                        (ex_taken_i && (ex_target_i != w_head_tgt));
  assign w_miss_jalr  = (ex_target_i != w_head_tgt);
  assign w_miss       = w_sync_bad || (ex_is_jalr_i ? w_miss_jalr : w_miss_br);
  assign w_mispredict = w_resolve && w_miss;
  assign w_next_pc    = calc_next_pc(ex_taken_i, ex_pc_i, ex_target_i);

  // Clearing on a mispredict also drops any push in that cycle (it is wrong-path).
  br_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_br_queue (
    .clk    (clk),
    .reset_n(reset_n),
    .i_push (w_push_fire),
    .i_data (w_push_data),
    .i_pop  (w_resolve),
    .i_clear(w_mispredict),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // IDLE/FLUSH control with registered outputs. flush_o rises with redirect_o and the
  // down-counter holds it for the remaining FLUSH_CYCLES-1 cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_flush_cnt   <= '0;
      br_sig_o      <= 1'b0;
      miss_pred_o   <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      flush_o       <= 1'b0;
      sync_err_o    <= 1'b0;
    end else begin
      br_sig_o    <= 1'b0;
      miss_pred_o <= 1'b0;
      redirect_o  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_resolve) begin
            br_sig_o    <= !ex_is_jalr_i;
            miss_pred_o <= !ex_is_jalr_i && w_miss;
            if (w_sync_bad) sync_err_o <= 1'b1;
            if (w_miss) begin
              redirect_o    <= 1'b1;
              redirect_pc_o <= w_next_pc;
              flush_o       <= 1'b1;
              r_flush_cnt   <= FcW'(FLUSH_CYCLES - 1);
              r_state       <= StFlush;
            end
          end
        end
        StFlush: begin
          if (r_flush_cnt == '0) begin
            flush_o <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Statistics cover BRANCH/JAL only; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      branch_cnt_o <= '0;
      miss_cnt_o   <= '0;
    end else if (w_resolve && !ex_is_jalr_i) begin
      branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (w_miss) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_br_resolver.sv
module tb_br_resolver;

  logic        clk;
  logic        reset_n;
  logic        push_valid_i;
  logic        push_pred_i;
  logic [31:0] push_pc_i;
  logic [31:0] push_target_i;
  logic        push_ready_o;
  logic        ex_valid_i;
  logic        ex_is_jalr_i;
  logic        ex_taken_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_target_i;
  logic        br_sig_o;
  logic        miss_pred_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        sync_err_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] miss_cnt_o;

  int n_tests;
  int n_fail;

  br_resolver #(
    .QUEUE_DEPTH (4),
    .FLUSH_CYCLES(2),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_valid_i (push_valid_i),
    .push_pred_i  (push_pred_i),
    .push_pc_i    (push_pc_i),
    .push_target_i(push_target_i),
    .push_ready_o (push_ready_o),
    .ex_valid_i   (ex_valid_i),
    .ex_is_jalr_i (ex_is_jalr_i),
    .ex_taken_i   (ex_taken_i),
    .ex_pc_i      (ex_pc_i),
    .ex_target_i  (ex_target_i),
    .br_sig_o     (br_sig_o),
    .miss_pred_o  (miss_pred_o),
    .redirect_o   (redirect_o),
    .redirect_pc_o(redirect_pc_o),
    .flush_o      (flush_o),
    .sync_err_o   (sync_err_o),
    .branch_cnt_o (branch_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_push(input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    push_valid_i  = 1'b1;
    push_pred_i   = pred;
    push_pc_i     = pc;
    push_target_i = tgt;
  endtask

  task automatic drive_ex(input logic jalr, input logic taken, input logic [31:0] pc,
                          input logic [31:0] tgt);
    ex_valid_i   = 1'b1;
    ex_is_jalr_i = jalr;
    ex_taken_i   = taken;
    ex_pc_i      = pc;
    ex_target_i  = tgt;
  endtask

  // One clock edge; outputs are sampled 1ns after it, then the valids drop.
  task automatic cycle();
    @(posedge clk);
    #1;
    push_valid_i = 1'b0;
    ex_valid_i   = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    push_valid_i  = 1'b0;
    push_pred_i   = 1'b0;
    push_pc_i     = '0;
    push_target_i = '0;
    ex_valid_i    = 1'b0;
    ex_is_jalr_i  = 1'b0;
    ex_taken_i    = 1'b0;
    ex_pc_i       = '0;
    ex_target_i   = '0;
    cycle();
    cycle();
    check("rst_ready", 32'(push_ready_o), 32'd1);
    check("rst_br_sig", 32'(br_sig_o), 32'd0);
    check("rst_redirect", 32'(redirect_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_sync_err", 32'(sync_err_o), 32'd0);
    check("rst_branch_cnt", branch_cnt_o, 32'd0);
    check("rst_miss_cnt", miss_cnt_o, 32'd0);
    reset_n = 1'b1;

    // 1: correctly predicted taken branch
    drive_push(1'b1, 32'h100, 32'h140);
    cycle();
    drive_ex(1'b0, 1'b1, 32'h100, 32'h140);
    cycle();
    check("t1_br_sig", 32'(br_sig_o), 32'd1);
    check("t1_miss", 32'(miss_pred_o), 32'd0);
    check("t1_redirect", 32'(redirect_o), 32'd0);
    check("t1_flush", 32'(flush_o), 32'd0);
    check("t1_branch_cnt", branch_cnt_o, 32'd1);
    check("t1_miss_cnt", miss_cnt_o, 32'd0);
    cycle();
    check("t1_br_sig_pulse", 32'(br_sig_o), 32'd0);

    // 2: predicted taken, actually not taken
    drive_push(1'b1, 32'h200, 32'h180);
    cycle();
    drive_ex(1'b0, 1'b0, 32'h200, 32'h180);
    cycle();
    check("t2_br_sig", 32'(br_sig_o), 32'd1);
    check("t2_miss", 32'(miss_pred_o), 32'd1);
    check("t2_redirect", 32'(redirect_o), 32'd1);
    check("t2_redirect_pc", redirect_pc_o, 32'h204);
    check("t2_flush1", 32'(flush_o), 32'd1);
    check("t2_ready_in_flush", 32'(push_ready_o), 32'd0);
    check("t2_branch_cnt", branch_cnt_o, 32'd2);
    check("t2_miss_cnt", miss_cnt_o, 32'd1);
    cycle();
    check("t2_flush2", 32'(flush_o), 32'd1);
    check("t2_redirect_pulse", 32'(redirect_o), 32'd0);
    cycle();
    check("t2_flush_end", 32'(flush_o), 32'd0);
    check("t2_ready_after", 32'(push_ready_o), 32'd1);

    // 3: JALR with wrong target; also confirms the queue was emptied by test 2
    drive_push(1'b0, 32'h300, 32'h304);
    cycle();
    drive_ex(1'b1, 1'b1, 32'h300, 32'h500);
    cycle();
    check("t3_redirect", 32'(redirect_o), 32'd1);
    check("t3_redirect_pc", redirect_pc_o, 32'h500);
    check("t3_br_sig", 32'(br_sig_o), 32'd0);
    check("t3_sync_err", 32'(sync_err_o), 32'd0);
    check("t3_branch_cnt", branch_cnt_o, 32'd2);
    check("t3_miss_cnt", miss_cnt_o, 32'd1);
    cycle();
    cycle();
    check("t3_flush_end", 32'(flush_o), 32'd0);

    // 4: fill the queue, then push+pop together, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b0, 32'h400 + 32'(4 * i), 32'h404 + 32'(4 * i));
      cycle();
    end
    check("t4_full_ready", 32'(push_ready_o), 32'd0);
    drive_ex(1'b0, 1'b0, 32'h400, 32'h0);
    cycle();
    check("t4_pop0_miss", 32'(miss_pred_o), 32'd0);
    check("t4_ready_3", 32'(push_ready_o), 32'd1);
    drive_push(1'b0, 32'h410, 32'h414);
    drive_ex(1'b0, 1'b0, 32'h404, 32'h0);
    cycle();
    check("t4_pushpop_miss", 32'(miss_pred_o), 32'd0);
    check("t4_pushpop_ready", 32'(push_ready_o), 32'd1);
    drive_push(1'b0, 32'h414, 32'h418);
    cycle();
    check("t4_refull_ready", 32'(push_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive_ex(1'b0, 1'b0, 32'h408 + 32'(4 * i), 32'h0);
      cycle();
      check("t4_drain_br_sig", 32'(br_sig_o), 32'd1);
      check("t4_drain_miss", 32'(miss_pred_o), 32'd0);
      check("t4_drain_redirect", 32'(redirect_o), 32'd0);
    end
    check("t4_sync_err", 32'(sync_err_o), 32'd0);
    check("t4_branch_cnt", branch_cnt_o, 32'd8);
    check("t4_miss_cnt", miss_cnt_o, 32'd1);
    check("t4_ready_empty", 32'(push_ready_o), 32'd1);

    // 5: PC mismatch against the head, then resolve on an empty queue
    drive_push(1'b0, 32'h400, 32'h404);
    cycle();
    drive_ex(1'b0, 1'b0, 32'h404, 32'h0);
    cycle();
    check("t5_sync_err", 32'(sync_err_o), 32'd1);
    check("t5_redirect", 32'(redirect_o), 32'd1);
    check("t5_redirect_pc", redirect_pc_o, 32'h408);
    check("t5_miss", 32'(miss_pred_o), 32'd1);
    cycle();
    cycle();
    drive_ex(1'b0, 1'b1, 32'h500, 32'h600);
    cycle();
    check("t5_empty_sync_err", 32'(sync_err_o), 32'd1);
    check("t5_empty_redirect_pc", redirect_pc_o, 32'h600);
    check("t5_branch_cnt", branch_cnt_o, 32'd10);
    check("t5_miss_cnt", miss_cnt_o, 32'd3);
    cycle();
    cycle();

    // 6a: reset in the second flush cycle
    drive_push(1'b1, 32'h600, 32'h640);
    cycle();
    drive_ex(1'b0, 1'b0, 32'h600, 32'h640);
    cycle();
    check("t6_redirect", 32'(redirect_o), 32'd1);
    cycle();
    check("t6_flush2", 32'(flush_o), 32'd1);
    reset_n = 1'b0;
    cycle();
    check("t6_rst_flush", 32'(flush_o), 32'd0);
    check("t6_rst_ready", 32'(push_ready_o), 32'd1);
    check("t6_rst_branch_cnt", branch_cnt_o, 32'd0);
    check("t6_rst_miss_cnt", miss_cnt_o, 32'd0);
    check("t6_rst_sync_err", 32'(sync_err_o), 32'd0);
    check("t6_rst_redirect_pc", redirect_pc_o, 32'd0);
    reset_n = 1'b1;

    // 6b: a push in the mispredict cycle is dropped
    drive_push(1'b1, 32'h800, 32'h840);
    cycle();
    drive_push(1'b1, 32'h900, 32'h940);
    drive_ex(1'b0, 1'b0, 32'h800, 32'h840);
    cycle();
    check("t6_drop_redirect_pc", redirect_pc_o, 32'h804);
    check("t6_drop_sync_err", 32'(sync_err_o), 32'd0);
    cycle();
    cycle();
    drive_ex(1'b0, 1'b1, 32'h900, 32'h940);
    cycle();
    check("t6_dropped_sync_err", 32'(sync_err_o), 32'd1);
    check("t6_dropped_redirect", 32'(redirect_o), 32'd1);
    check("t6_dropped_redirect_pc", redirect_pc_o, 32'h940);
    check("t6_branch_cnt", branch_cnt_o, 32'd2);
    check("t6_miss_cnt", miss_cnt_o, 32'd2);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
